multicycle_control_unit: RTL and testbench

//  Multi-cycle control FSM for the 32-bit MIPS datapath; successor to the single-cycle decoder.

---
 rtl/mips_ctrl_pkg.sv | 36 +++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcode/funct values,
// controller state encoding and PC source select values.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    // PC source select driven onto the datapath mux
    localparam logic [1:0] PCSRC_PC4 = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;
    localparam logic [1:0] PCSRC_REG = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM_RD = 4'd4,
        ST_MEM_WR = 4'd5,
        ST_WB     = 4'd6,
        ST_BRANCH = 4'd7,
        ST_JUMP   = 4'd8,
        ST_ERROR  = 4'd9
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without mem_ready and
// flags a timeout on the cycle the count would reach 2**WAIT_W-1.
module mem_wait_timer #(
    parameter int WAIT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,      // no request pending, or request completing
    input  logic en_i,       // request pending and not ready this cycle
    output logic timeout_o
);

    // Last count value before the limit; one more unanswered cycle is a timeout.
    localparam logic [WAIT_W-1:0] LAST = WAIT_W'((2 ** WAIT_W) - 2);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Wait-count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction through fetch,
// decode, execute, memory and write-back, drives the datapath enables, counts
// retired instructions and latches a sticky error on a memory timeout.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32,
    parameter logic [OPCODE_W-1:0] OP_LUI = OPCODE_W'(15)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                RegRead,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegDst,
    output logic                Branch,
    output logic                MemToReg,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                err,
    output logic [CNT_W-1:0]    retired,
    output state_t              dbg_state_o
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   retired_q;
    logic [CNT_W-1:0]   retired_d;
    logic               retire;
    logic               timeout;
    logic               wait_clr;
    logic               wait_en;

    function automatic logic op_is(input logic [OPCODE_W-1:0] op, input logic [5:0] code);
        return op == OPCODE_W'(code);
    endfunction

    logic is_rtype;
    logic is_jr;
    logic is_branch;
    logic is_jtype;
    logic is_lw;
    logic is_store;

    assign is_rtype  = op_is(opcode, OP_RTYPE);
    assign is_jr     = is_rtype && (funct == FUNCT_W'(FN_JR));
    assign is_branch = op_is(opcode, OP_BEQ) || op_is(opcode, OP_BNE);
    assign is_jtype  = op_is(opcode, OP_J) || op_is(opcode, OP_JAL);
    assign is_lw     = op_is(opcode, OP_LW);
    assign is_store  = op_is(opcode, OP_SB) || op_is(opcode, OP_SH) || op_is(opcode, OP_SW);

    // The counter only runs while a request is outstanding and unanswered.
    assign wait_clr = !mem_req || mem_ready;
    assign wait_en  = mem_req && !mem_ready;

    mem_wait_timer #(
        .WAIT_W (WAIT_W)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (wait_clr),
        .en_i      (wait_en),
        .timeout_o (timeout)
    );

    // Next-state and datapath enables, decoded from state (plus mem_ready in memory states).
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        mem_req  = 1'b0;
        RegRead  = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegDst   = 1'b0;
        Branch   = 1'b0;
        MemToReg = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PCSRC_PC4;
        err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_PC4;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                RegRead = (opcode != OP_LUI);
                if (is_jr || is_jtype)  state_d = ST_JUMP;
                else if (is_branch)     state_d = ST_BRANCH;
                else                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_lw)          state_d = ST_MEM_RD;
                else if (is_store)  state_d = ST_MEM_WR;
                else                state_d = ST_WB;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready)     state_d = ST_WB;
                else if (timeout)  state_d = ST_ERROR;
            end
            ST_MEM_WR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                RegRead  = 1'b1;
                if (mem_ready)     retire  = 1'b1;
                else if (timeout)  state_d = ST_ERROR;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_rtype;
                MemToReg = is_lw;
                retire   = 1'b1;
            end
            ST_BRANCH: begin
                Branch = 1'b1;
                PCSrc  = PCSRC_BR;
                retire = 1'b1;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSrc    = is_jr ? PCSRC_REG : PCSRC_JMP;
                RegWrite = op_is(opcode, OP_JAL);
                retire   = 1'b1;
            end
            ST_ERROR: begin
                err = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Instruction boundary: run decides whether to keep fetching.
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    // Retired-instruction count, wrapping modulo 2**CNT_W.
    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired     = retired_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit (WAIT_W=2, CNT_W=4). Each instruction is
// expanded into a per-cycle list of expected enable vectors and drive values,
// then played cycle by cycle.
module tb_multicycle_control_unit;
    import mips_ctrl_pkg::*;

    localparam int WAIT_W = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             mem_req, RegRead, RegWrite, MemRead, MemWrite;
    logic             RegDst, Branch, MemToReg, IRWrite, PCWrite;
    logic [1:0]       PCSrc;
    logic             err;
    logic [CNT_W-1:0] retired;
    state_t           dbg_state;

    logic [12:0]      act;
    logic [12:0]      exp_q[$];
    logic [2:0]       drv_q[$];   // {opcode valid, run, mem_ready}

    int               n_cmp = 0;
    int               n_err = 0;
    int               ret_m = 0;
    bit               in_idle = 1'b1;
    logic [5:0]       cur_op;
    logic [5:0]       cur_fn;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OPCODE_W (6),
        .FUNCT_W  (6),
        .WAIT_W   (WAIT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .RegRead     (RegRead),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegDst      (RegDst),
        .Branch      (Branch),
        .MemToReg    (MemToReg),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .err         (err),
        .retired     (retired),
        .dbg_state_o (dbg_state)
    );

    assign act = {mem_req, RegRead, RegWrite, MemRead, MemWrite, RegDst,
                  Branch, MemToReg, IRWrite, PCWrite, PCSrc, err};

    function automatic logic [12:0] v(input logic mr, input logic rr, input logic rw,
                                      input logic mrd, input logic mw, input logic rd,
                                      input logic br, input logic m2r, input logic irw,
                                      input logic pcw, input logic [1:0] ps, input logic e);
        return {mr, rr, rw, mrd, mw, rd, br, m2r, irw, pcw, ps, e};
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] d, input logic [12:0] e);
        drv_q.push_back(d);
        exp_q.push_back(e);
    endtask

    // Drive each queued cycle, compare enables mid-cycle, advance one clock.
    task automatic play();
        logic [2:0]  d;
        logic [12:0] e;
        int          idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            d = drv_q.pop_front();
            e = exp_q.pop_front();
            run       = d[1];
            mem_ready = d[0];
            if (d[2]) begin
                opcode = cur_op;
                funct  = cur_fn;
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            @(negedge clk);
            check($sformatf("ctl op=%02h fn=%02h cyc=%0d", cur_op, cur_fn, idx), act, e);
            @(posedge clk);
            #1;
            idx++;
        end
    endtask

    task automatic push_idle_start();
        if (in_idle) begin
            push({1'b0, 1'b0, rb()}, 13'b0);
            push({1'b0, 1'b1, rb()}, 13'b0);
        end
    endtask

    // One instruction: fw not-ready fetch cycles, mw not-ready memory cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic run_after);
        bit jr, rt, br, jmp, lw, st;
        cur_op = op;
        cur_fn = fn;
        jr  = (op == 6'h00) && (fn == 6'h08);
        rt  = (op == 6'h00) && !jr;
        br  = (op == 6'h04) || (op == 6'h05);
        jmp = (op == 6'h02) || (op == 6'h03);
        lw  = (op == 6'h23);
        st  = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
        push_idle_start();
        for (int i = 0; i < fw; i++) push({1'b0, rb(), 1'b0}, v(1,0,0,1,0,0,0,0,0,0,2'd0,0));
        push({1'b0, rb(), 1'b1}, v(1,0,0,1,0,0,0,0,1,1,2'd0,0));
        push({1'b1, rb(), rb()}, v(0,(op != 6'h0F),0,0,0,0,0,0,0,0,2'd0,0));
        if (br) begin
            push({1'b1, run_after, rb()}, v(0,0,0,0,0,0,1,0,0,0,2'd1,0));
        end else if (jmp || jr) begin
            push({1'b1, run_after, rb()},
                 v(0,0,(op == 6'h03),0,0,0,0,0,0,1,(jr ? 2'd3 : 2'd2),0));
        end else begin
            push({1'b1, rb(), rb()}, 13'b0);
            if (lw) begin
                for (int i = 0; i < mw; i++) push({1'b1, rb(), 1'b0}, v(1,0,0,1,0,0,0,0,0,0,2'd0,0));
                push({1'b1, rb(), 1'b1}, v(1,0,0,1,0,0,0,0,0,0,2'd0,0));
                push({1'b1, run_after, rb()}, v(0,0,1,0,0,0,0,1,0,0,2'd0,0));
            end else if (st) begin
                for (int i = 0; i < mw; i++) push({1'b1, rb(), 1'b0}, v(1,1,0,0,1,0,0,0,0,0,2'd0,0));
                push({1'b1, run_after, 1'b1}, v(1,1,0,0,1,0,0,0,0,0,2'd0,0));
            end else begin
                push({1'b1, run_after, rb()}, v(0,0,1,0,0,rt,0,0,0,0,2'd0,0));
            end
        end
        play();
        ret_m   = (ret_m + 1) % (2 ** CNT_W);
        in_idle = !run_after;
        check($sformatf("retired op=%02h", op), 32'(retired), 32'(ret_m));
    endtask

    logic [5:0] op_tab [12];
    logic [5:0] rop;
    logic [5:0] rfn;

    initial begin
        op_tab = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                   6'h0F, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h08};
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
        cur_op = '0; cur_fn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_enables", act, 13'b0);
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;

        // Directed instruction mix.
        run_instr(6'h00, 6'h20, 0, 0, 1'b1);  // add
        run_instr(6'h23, 6'h00, 0, 2, 1'b1);  // lw, ready on 3rd MEM_RD cycle
        run_instr(6'h2B, 6'h11, 1, 1, 1'b1);  // sw
        run_instr(6'h00, 6'h08, 0, 0, 1'b1);  // jr
        run_instr(6'h03, 6'h00, 2, 0, 1'b1);  // jal, ready on 3rd FETCH cycle
        run_instr(6'h04, 6'h00, 0, 0, 1'b0);  // beq, then idle
        run_instr(6'h02, 6'h00, 0, 0, 1'b1);  // j
        run_instr(6'h0F, 6'h00, 0, 0, 1'b1);  // lui
        run_instr(6'h08, 6'h00, 1, 0, 1'b0);  // addi, then idle
        run_instr(6'h05, 6'h00, 0, 0, 1'b1);  // bne
        run_instr(6'h20, 6'h00, 0, 0, 1'b1);  // lb: plain ALU path

        // Random mix; the 4-bit retired count wraps several times.
        for (int n = 0; n < 41; n++) begin
            rop = op_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 5) == 0) rop = 6'($urandom);
            rfn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 2), logic'($urandom_range(0, 3) != 0));
        end

        // Reset while a store is waiting in MEM_WR.
        cur_op = 6'h2B; cur_fn = 6'h00;
        push_idle_start();
        push({1'b0, 1'b1, 1'b1}, v(1,0,0,1,0,0,0,0,1,1,2'd0,0));
        push({1'b1, 1'b1, rb()}, v(0,1,0,0,0,0,0,0,0,0,2'd0,0));
        push({1'b1, 1'b1, rb()}, 13'b0);
        push({1'b1, 1'b1, 1'b0}, v(1,1,0,0,1,0,0,0,0,0,2'd0,0));
        play();
        mem_ready = 1'b0;
        #1;
        check("memwr_before_reset", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("memwr_at_reset", 32'(MemWrite), 32'd0);
        check("enables_at_reset", act, 13'b0);
        check("retired_at_reset", 32'(retired), 32'd0);
        check("state_at_reset", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        ret_m = 0;
        in_idle = 1'b1;
        run_instr(6'h00, 6'h22, 0, 0, 1'b1);  // sub after reset

        // Fetch never answered: ERROR after three waiting cycles, sticky.
        cur_op = 6'h00; cur_fn = 6'h20;
        push_idle_start();
        for (int i = 0; i < 3; i++) push({1'b0, rb(), 1'b0}, v(1,0,0,1,0,0,0,0,0,0,2'd0,0));
        for (int i = 0; i < 5; i++) push({1'b0, rb(), rb()}, v(0,0,0,0,0,0,0,0,0,0,2'd0,1));
        play();
        check("retired_in_error", 32'(retired), 32'(ret_m));
        reset = 1'b1;
        #1;
        check("err_cleared_by_reset", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
